// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display path.
//   - Glyph codes for the non-hex symbols (values 0..15 are hex digits 0..F).
//   - SEG_BLANK: all segments and the decimal point off (outputs are active-low).
//   - glyph_to_seg(): 5-bit glyph code plus decimal point -> active-low {a,b,c,d,e,f,g,dp}.
package seven_seg_pkg;

  localparam logic [4:0] GLY_MINUS = 5'd16;
  localparam logic [4:0] GLY_BLANK = 5'd17;
  localparam logic [4:0] GLY_E     = 5'd18;
  localparam logic [4:0] GLY_R     = 5'd19;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Codes 20..31 are reserved and render blank.
  function automatic logic [7:0] glyph_to_seg(input logic [4:0] glyph, input logic dp);
    logic [7:0] s;
    case (glyph)
      5'd0:      s = 8'h03;
      5'd1:      s = 8'h9F;
      5'd2:      s = 8'h25;
      5'd3:      s = 8'h0D;
      5'd4:      s = 8'h99;
      5'd5:      s = 8'h49;
      5'd6:      s = 8'h41;
      5'd7:      s = 8'h1F;
      5'd8:      s = 8'h01;
      5'd9:      s = 8'h09;
      5'd10:     s = 8'h11;
      5'd11:     s = 8'hC1;
      5'd12:     s = 8'h63;
      5'd13:     s = 8'h85;
      5'd14:     s = 8'h61;
      5'd15:     s = 8'h71;
      GLY_MINUS: s = 8'hFD;
      GLY_E:     s = 8'h61;
      GLY_R:     s = 8'hF5;
      default:   s = SEG_BLANK;
    endcase
    // The decimal point is independent of the glyph, so even a blank glyph can show it.
    return {s[7:1], s[0] & ~dp};
  endfunction

endpackage

// File: rtl/seven_seg_glyph_decoder.sv
// Combinational glyph decoder.
//   glyph : 5-bit glyph code
//   dp    : 1 = decimal point lit
//   seg   : active-low {a,b,c,d,e,f,g,dp}
module seven_seg_glyph_decoder
  import seven_seg_pkg::*;
(
  input  logic [4:0] glyph,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = glyph_to_seg(glyph, dp);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scan driver.
//   clk, rst     : clock and synchronous active-high reset
//   en           : 1 = drive the display, 0 = outputs dark while the scan keeps running
//   load         : strobe that captures glyphs/dp/lz_suppress into the shadow registers
//   glyphs       : 5-bit glyph per digit, digit i = glyphs[5*i+4:5*i], digit 0 rightmost
//   dp           : decimal point per digit, 1 = lit
//   lz_suppress  : 1 = blank leading zero glyphs (digit 0 is never blanked)
//   brightness   : PWM on-time, 0 = dimmest, all-ones = full
//   seg, an      : registered active-low segment and anode drives
//   frame_done   : one-cycle pulse when the active registers take the shadow contents
// Each digit owns DWELL cycles. Cycle 0 of a dwell keeps every anode off so the segment
// change for the new digit cannot ghost onto the neighbouring digit.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 100_000_000,
  parameter int FRAME_HZ   = 1_000,
  parameter int BRIGHT_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [5*NUM_DIGITS-1:0] glyphs,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int DWELL = CLK_HZ / (FRAME_HZ * NUM_DIGITS);
  localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IW    = $clog2(NUM_DIGITS);

  if (DWELL < (1 << BRIGHT_W)) begin : g_bad_dwell
    $error("seven_seg_scan_driver: DWELL too short for BRIGHT_W brightness levels");
  end
  if (NUM_DIGITS < 2) begin : g_bad_digits
    $error("seven_seg_scan_driver: NUM_DIGITS must be at least 2");
  end

  logic [CW-1:0] dwell_cnt;
  logic [IW-1:0] digit_idx;

  logic [4:0]            shadow_glyph [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic                  shadow_lz;
  logic [4:0]            active_glyph [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] active_dp;
  logic                  active_lz;

  logic dwell_wrap;
  logic frame_wrap;
  assign dwell_wrap = (dwell_cnt == CW'(DWELL - 1));
  assign frame_wrap = dwell_wrap && (digit_idx == IW'(NUM_DIGITS - 1));

  // Leading-zero mask: walk down from the top digit while glyphs are literal zero.
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  lz_run;
  always_comb begin
    // NOTE: every variable gets a default before any conditional path; otherwise a latch is inferred.
    lz_blank = '0;
    lz_run   = active_lz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_run      = lz_run && (active_glyph[i] == 5'd0);
      lz_blank[i] = lz_run;
    end
  end

  logic [4:0] cur_glyph;
  logic       cur_dp;
  logic [7:0] cur_seg;
  assign cur_glyph = lz_blank[digit_idx] ? GLY_BLANK : active_glyph[digit_idx];
  assign cur_dp    = active_dp[digit_idx];

  seven_seg_glyph_decoder u_decoder (
    .glyph (cur_glyph),
    .dp    (cur_dp),
    .seg   (cur_seg)
  );

  // PWM on-window: dwell cycles 1..on_cycles, capped so the blanking cycle always survives.
  int  on_cycles;
  logic lit;
  always_comb begin
    on_cycles = ((int'(brightness) + 1) * DWELL) >> BRIGHT_W;
    if (on_cycles > DWELL - 1) on_cycles = DWELL - 1;
    lit = (dwell_cnt != '0) && (int'(dwell_cnt) <= on_cycles);
  end

  logic [NUM_DIGITS-1:0] digit_onehot;
  always_comb begin
    digit_onehot            = '0;
    digit_onehot[digit_idx] = 1'b1;
  end

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt  <= '0;
      digit_idx  <= '0;
      seg        <= SEG_BLANK;
      an         <= '1;
      frame_done <= 1'b0;
      // NOTE: these small glyph arrays are reset on purpose: the display must come up blank.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_glyph[i] <= GLY_BLANK;
        active_glyph[i] <= GLY_BLANK;
      end
      shadow_dp <= '0;
      active_dp <= '0;
      shadow_lz <= 1'b0;
      active_lz <= 1'b0;
    end else begin
      frame_done <= frame_wrap;

      if (dwell_wrap) begin
        dwell_cnt <= '0;
        digit_idx <= (digit_idx == IW'(NUM_DIGITS - 1)) ? '0 : digit_idx + IW'(1);
      end else begin
        dwell_cnt <= dwell_cnt + CW'(1);
      end

      // Active takes the pre-load shadow, so a load on the boundary cycle shows a frame later.
      if (frame_wrap) begin
        active_glyph <= shadow_glyph;
        active_dp    <= shadow_dp;
        active_lz    <= shadow_lz;
      end

      if (load) begin
        for (int i = 0; i < NUM_DIGITS; i++) shadow_glyph[i] <= glyphs[5*i +: 5];
        shadow_dp <= dp;
        shadow_lz <= lz_suppress;
      end

      seg <= en ? cur_seg : SEG_BLANK;
      an  <= (en && lit) ? ~digit_onehot : '1;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver with NUM_DIGITS=4, DWELL=4, BRIGHT_W=2.
// A cycle-count based model predicts seg/an/frame_done every cycle; directed frame checks
// pin the model with hand-computed segment bytes.
module tb_seven_seg_scan_driver;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int BW = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic         load = 1'b0;
  logic [19:0]  glyphs = '0;
  logic [3:0]   dp = '0;
  logic         lz_suppress = 1'b0;
  logic [1:0]   brightness = 2'd3;
  logic [7:0]   seg;
  logic [3:0]   an;
  logic         frame_done;

  int n_vec = 0;
  int n_bad = 0;

  seven_seg_scan_driver #(
    .NUM_DIGITS (N),
    .CLK_HZ     (1600),
    .FRAME_HZ   (100),
    .BRIGHT_W   (BW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .glyphs      (glyphs),
    .dp          (dp),
    .lz_suppress (lz_suppress),
    .brightness  (brightness),
    .seg         (seg),
    .an          (an),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] pat [32] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                           8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71,
                           8'hFD, 8'hFF, 8'h61, 8'hF5, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                           8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  int         t;
  logic [4:0] sh_g [N];
  logic [4:0] ac_g [N];
  logic [3:0] sh_dp, ac_dp;
  logic       sh_lz, ac_lz;
  logic [7:0] exp_seg;
  logic [3:0] exp_an;
  logic       exp_fd;
  logic       model_valid = 1'b0;

  function automatic logic [7:0] model_seg(input int d);
    logic       all_zero = 1'b1;
    logic [7:0] s;
    for (int j = d; j < N; j++) if (ac_g[j] != 5'd0) all_zero = 1'b0;
    if (ac_lz && d > 0 && all_zero) s = 8'hFF;
    else s = pat[ac_g[d]];
    if (ac_dp[d]) s[0] = 1'b0;
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      t = 0;
      for (int i = 0; i < N; i++) begin
        sh_g[i] = 5'd17;
        ac_g[i] = 5'd17;
      end
      sh_dp = '0; ac_dp = '0; sh_lz = 1'b0; ac_lz = 1'b0;
      exp_seg = 8'hFF; exp_an = 4'hF; exp_fd = 1'b0;
      model_valid = 1'b1;
    end else begin
      int d, ph, on, b;
      d  = (t / DW) % N;
      ph = t % DW;
      b  = brightness;
      on = ((b + 1) * DW) >> BW;
      if (on > DW - 1) on = DW - 1;
      exp_seg = en ? model_seg(d) : 8'hFF;
      exp_an  = (en && ph >= 1 && ph <= on) ? ~(4'b0001 << d) : 4'hF;
      exp_fd  = (t % (DW * N)) == (DW * N - 1);
      if (exp_fd) begin
        ac_g = sh_g; ac_dp = sh_dp; ac_lz = sh_lz;
      end
      if (load) begin
        for (int i = 0; i < N; i++) sh_g[i] = glyphs[5*i +: 5];
        sh_dp = dp; sh_lz = lz_suppress;
      end
      t++;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_seg", {24'h0, seg}, {24'h0, exp_seg});
      check("model_an", {28'h0, an}, {28'h0, exp_an});
      check("model_frame_done", {31'h0, frame_done}, {31'h0, exp_fd});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_fd();
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    if (!seen) check("frame_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_vals(input logic [19:0] g, input logic [3:0] d, input logic lz);
    glyphs = g; dp = d; lz_suppress = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Called at a frame_done negedge; checks the 16 output cycles of the next frame.
  task automatic check_frame(input logic [31:0] exp_segs, input int on, input string tag);
    for (int j = 1; j <= 16; j++) begin
      int d, ph;
      logic [3:0] ea;
      @(negedge clk);
      d  = (j - 1) / 4;
      ph = (j - 1) % 4;
      ea = (ph == 0 || ph > on) ? 4'hF : ~(4'b0001 << d);
      check({tag, "_seg"}, {24'h0, seg}, {24'h0, exp_segs[8*d +: 8]});
      check({tag, "_an"}, {28'h0, an}, {28'h0, ea});
      if (j == 16) check({tag, "_fd"}, {31'h0, frame_done}, 32'd1);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_seg", {24'h0, seg}, 32'hFF);
    check("rst_an", {28'h0, an}, 32'hF);
    check("rst_fd", {31'h0, frame_done}, 32'd0);
    rst = 1'b0;

    wait_fd();
    check_frame(32'hFFFF_FFFF, 3, "blank_frame");

    load_vals({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 1'b0);
    wait_fd();
    check_frame({8'h0D, 8'h25, 8'h9F, 8'h03}, 3, "digits_bright3");

    brightness = 2'd0;
    wait_fd();
    check_frame({8'h0D, 8'h25, 8'h9F, 8'h03}, 1, "digits_bright0");
    brightness = 2'd3;

    load_vals({5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000, 1'b1);
    wait_fd();
    check_frame({8'hFF, 8'hFF, 8'hFF, 8'h03}, 3, "lz_all_zero");

    load_vals({5'd0, 5'd16, 5'd0, 5'd5}, 4'b0000, 1'b1);
    wait_fd();
    check_frame({8'hFF, 8'hFD, 8'h03, 8'h49}, 3, "lz_minus");

    load_vals({5'd0, 5'd0, 5'd0, 5'd8}, 4'b0001, 1'b1);
    wait_fd();
    check_frame({8'hFF, 8'hFF, 8'hFF, 8'h00}, 3, "lz_dp0");

    load_vals({5'd1, 5'd0, 5'd0, 5'd0}, 4'b0010, 1'b1);
    wait_fd();
    check_frame({8'h9F, 8'h03, 8'h02, 8'h03}, 3, "lz_stop_dp1");

    // Two loads in one frame: the second must win.
    load_vals({5'd5, 5'd5, 5'd5, 5'd5}, 4'b0000, 1'b0);
    load_vals({5'd18, 5'd19, 5'd17, 5'd20}, 4'b0000, 1'b0);
    wait_fd();
    check_frame({8'h61, 8'hF5, 8'hFF, 8'hFF}, 3, "letters_last_load");

    // Load on the frame-boundary cycle: old data one more frame, then the new data.
    wait_fd();
    repeat (15) @(negedge clk);
    glyphs = {5'd9, 5'd9, 5'd9, 5'd9}; dp = 4'b0000; lz_suppress = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("boundary_fd", {31'h0, frame_done}, 32'd1);
    check_frame({8'h61, 8'hF5, 8'hFF, 8'hFF}, 3, "boundary_old");
    check_frame({8'h09, 8'h09, 8'h09, 8'h09}, 3, "boundary_new");

    // en low mid-frame: dark outputs, scan and frame_done continue.
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en0_seg", {24'h0, seg}, 32'hFF);
    check("en0_an", {28'h0, an}, 32'hF);
    wait_fd();
    check("en0_fd", {31'h0, frame_done}, 32'd1);
    check("en0_seg_at_fd", {24'h0, seg}, 32'hFF);
    en = 1'b1;

    // Reset mid-scan.
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_seg", {24'h0, seg}, 32'hFF);
    check("midrst_an", {28'h0, an}, 32'hF);
    check("midrst_fd", {31'h0, frame_done}, 32'd0);
    rst = 1'b0;
    wait_fd();
    check_frame(32'hFFFF_FFFF, 3, "post_rst_blank");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
